// File: rtl/ov7670_emulator.sv
// ov7670_emulator: replays a frame buffer as an OV7670-style pclk/vsync/href/data stream; OV7670_EMU_TESTPAT_EN adds colour bars
module ov7670_emulator #(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_vsync_pclks  = 3,
    parameter int c_vback_pclks  = 17,
    parameter int c_hblank_pclks = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     swap_r_b,
    input  logic                     test_pattern,
    output logic [c_nb_img_pxls-1:0] rd_addr,
    input  logic [15:0]              rd_data,
    output logic                     pclk,
    output logic                     vsync,
    output logic                     href,
    output logic [7:0]               data,
    output logic                     frame_done
);
    localparam logic [2:0] IDLE = 3'd0, VSYNC = 3'd1, VBACK = 3'd2, LINE = 3'd3, HBLANK = 3'd4;
    localparam int c_line = 2 * c_img_cols;
    localparam int c_m1 = c_vsync_pclks > c_vback_pclks ? c_vsync_pclks : c_vback_pclks;
    localparam int c_m2 = c_hblank_pclks > c_line ? c_hblank_pclks : c_line;
    localparam int c_cmax = c_m1 > c_m2 ? c_m1 : c_m2;
    localparam int c_cw = $clog2(c_cmax + 1);
    localparam int c_rw = $clog2(c_img_rows + 1);
    localparam logic [c_nb_img_pxls-1:0] c_last = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);

    logic [2:0]      state;
    logic [c_cw-1:0] cnt;
    logic [c_rw-1:0] row;
    logic            swap_q;
    logic [7:0]      pix_lo;
    logic [15:0]     src, px;
    logic            vs_end, vb_end, ln_end, hb_end, last_row, load, start;

`ifdef OV7670_EMU_TESTPAT_EN
    localparam int c_bw = c_img_cols / 8 < 1 ? 1 : c_img_cols / 8;
    localparam logic [127:0] c_bars = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                       16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
    logic            tp_q;
    logic [c_cw-1:0] col, bar_i;
    logic [2:0]      bar;
    // column of the pixel about to be loaded selects its colour bar
    always_comb begin
        col   = state == LINE ? (cnt + 1'b1) >> 1 : '0;
        bar_i = col / c_cw'(c_bw);
        bar   = bar_i > c_cw'(7) ? 3'd7 : bar_i[2:0];
        src   = tp_q ? c_bars[{bar, 4'b0} +: 16] : rd_data;
    end
`else
    logic unused_tp;
    assign unused_tp = test_pattern;
    assign src = rd_data;
`endif

    // period-end strobes; all fire on the clk edge where pclk falls
    always_comb begin
        vs_end   = pclk && state == VSYNC && cnt == c_cw'(c_vsync_pclks - 1);
        vb_end   = pclk && state == VBACK && cnt == c_cw'(c_vback_pclks - 1);
        ln_end   = pclk && state == LINE && cnt == c_cw'(c_line - 1);
        hb_end   = pclk && state == HBLANK && cnt == c_cw'(c_hblank_pclks - 1);
        last_row = row == c_rw'(c_img_rows - 1);
        load     = vb_end || (hb_end && !last_row) || (pclk && state == LINE && cnt[0] && !ln_end);
        start    = enable && (state == IDLE || (hb_end && last_row));
        px       = swap_q ? {src[4:0], src[10:5], src[15:11]} : src;
    end

    // frame sequencer: state, period counter, row counter, sync outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            pclk       <= 1'b0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            frame_done <= 1'b0;
            swap_q     <= 1'b0;
`ifdef OV7670_EMU_TESTPAT_EN
            tp_q       <= 1'b0;
`endif
        end else begin
            pclk       <= state == IDLE ? 1'b0 : ~pclk;
            frame_done <= hb_end && last_row;
            if (start) begin
                state  <= VSYNC;
                vsync  <= 1'b1;
                cnt    <= '0;
                row    <= '0;
                swap_q <= swap_r_b;
`ifdef OV7670_EMU_TESTPAT_EN
                tp_q   <= test_pattern;
`endif
            end else if (hb_end && last_row) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (pclk && state != IDLE) begin
                cnt <= cnt + 1'b1;
                if (vs_end) begin
                    state <= VBACK;
                    vsync <= 1'b0;
                    cnt   <= '0;
                end
                if (vb_end || hb_end) begin
                    state <= LINE;
                    href  <= 1'b1;
                    cnt   <= '0;
                end
                if (hb_end) row <= row + 1'b1;
                if (ln_end) begin
                    state <= HBLANK;
                    href  <= 1'b0;
                    cnt   <= '0;
                end
            end
        end
    end

    // pixel fetch and byte serialiser: address runs one pixel ahead of the byte stream
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
            data    <= 8'h00;
            pix_lo  <= 8'h00;
        end else begin
            if (start) rd_addr <= '0;
            else if (load) rd_addr <= rd_addr == c_last ? '0 : rd_addr + 1'b1;
            if (load) begin
                data   <= px[15:8];
                pix_lo <= px[7:0];
            end else if (pclk && state == LINE) data <= cnt[0] ? 8'h00 : pix_lo;
        end
    end
endmodule
